// File: rtl/crypto_job_if.sv
// Requester-side job/response bus of the crypto job sequencer.
// The master modport is the requester cluster; the slave modport is the sequencer.
interface crypto_job_if #(
   parameter int unsigned N_CH   = 4,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned KEY_W  = 16
);
   logic [N_CH-1:0]        req_valid;
   logic [N_CH-1:0]        req_ready;
   logic [2*N_CH-1:0]      req_mode;
   logic [KEY_W*N_CH-1:0]  req_key;
   logic [DATA_W*N_CH-1:0] req_data;
   logic [N_CH-1:0]        rsp_valid;
   logic [N_CH-1:0]        rsp_ready;
   logic [DATA_W-1:0]      rsp_data;
   logic                   rsp_err;

   modport master (
      output req_valid, req_mode, req_key, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_mode, req_key, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/crypto_job_sequencer.sv
// crypto_job_sequencer: round-robin front end for the crypto core. Accepts one job at a
// time from N_CH requesters, reloads the core (reset pulse) only when key or mode
// changed, starts the core, waits for fin with a timeout, and returns the result to
// the owning channel.
module crypto_job_sequencer #(
   parameter int unsigned N_CH    = 4,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned KEY_W   = 16,
   parameter int unsigned RST_CYC = 1,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   crypto_job_if.slave       job,
   output logic              core_rst_n_o,
   output logic [KEY_W-1:0]  core_key_o,
   output logic [1:0]        core_mode_o,
   output logic [DATA_W-1:0] core_data_o,
   output logic              core_bgn_o,
   input  logic              core_fin_i,
   input  logic [DATA_W-1:0] core_dout_i,
   output logic              busy_o
);

   localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned SUM_W = CH_W + 1;
   localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned RC_W  = 4;

   localparam logic [1:0] MODE_ENC = 2'b01;
   localparam logic [1:0] MODE_DEC = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_KRST  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_RESP  = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic                key_loaded_q, key_loaded_d;
   logic [KEY_W-1:0]    last_key_q, last_key_d;
   logic [1:0]          last_mode_q, last_mode_d;
   logic [KEY_W-1:0]    core_key_q, core_key_d;
   logic [1:0]          core_mode_q, core_mode_d;
   logic [DATA_W-1:0]   core_data_q, core_data_d;
   logic                core_rst_n_q, core_rst_n_d;
   logic                core_bgn_q, core_bgn_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [RC_W-1:0]     rcnt_q, rcnt_d;
   logic [N_CH-1:0]     rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_err_q, rsp_err_d;
   logic                busy_q, busy_d;

   logic [CH_W-1:0]     grant_c;
   logic                grant_vld_c;
   logic [1:0]          sel_mode_c;
   logic [KEY_W-1:0]    sel_key_c;
   logic [DATA_W-1:0]   sel_data_c;
   logic                sel_mode_ok_c;
   logic                need_reload_c;

   // Round-robin pick: first requesting channel at or after rr_ptr, with wrap.
   always_comb begin
      logic [SUM_W-1:0] idx;
      grant_c     = '0;
      grant_vld_c = 1'b0;
      idx         = '0;
      for (int i = int'(N_CH) - 1; i >= 0; i--) begin
         idx = {1'b0, rr_ptr_q} + SUM_W'(i);
         if (idx >= SUM_W'(N_CH)) begin
            idx = idx - SUM_W'(N_CH);
         end
         if (job.req_valid[idx[CH_W-1:0]]) begin
            grant_c     = idx[CH_W-1:0];
            grant_vld_c = 1'b1;
         end
      end
   end

   // Payload of the granted channel and the reload decision against the loaded key/mode.
   always_comb begin
      sel_mode_c    = job.req_mode[grant_c*2 +: 2];
      sel_key_c     = job.req_key[grant_c*KEY_W +: KEY_W];
      sel_data_c    = job.req_data[grant_c*DATA_W +: DATA_W];
      sel_mode_ok_c = (sel_mode_c == MODE_ENC) || (sel_mode_c == MODE_DEC);
      need_reload_c = !key_loaded_q || (sel_key_c != last_key_q) || (sel_mode_c != last_mode_q);
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      ch_d          = ch_q;
      key_loaded_d  = key_loaded_q;
      last_key_d    = last_key_q;
      last_mode_d   = last_mode_q;
      core_key_d    = core_key_q;
      core_mode_d   = core_mode_q;
      core_data_d   = core_data_q;
      timer_d       = timer_q;
      rcnt_d        = rcnt_q;
      rsp_data_d    = rsp_data_q;
      rsp_err_d     = rsp_err_q;
      job.req_ready = '0;

      unique case (state_q)
         S_IDLE: begin
            if (grant_vld_c) begin
               job.req_ready[grant_c] = 1'b1;
               ch_d = grant_c;
               if (!sel_mode_ok_c) begin
                  rsp_data_d = '0;
                  rsp_err_d  = 1'b1;
                  state_d    = S_RESP;
               end else begin
                  core_key_d  = sel_key_c;
                  core_mode_d = sel_mode_c;
                  core_data_d = sel_data_c;
                  if (need_reload_c) begin
                     rcnt_d  = RC_W'(RST_CYC - 1);
                     state_d = S_KRST;
                  end else begin
                     state_d = S_START;
                  end
               end
            end
         end
         S_KRST: begin
            if (rcnt_q == '0) begin
               state_d = S_START;
            end else begin
               rcnt_d = rcnt_q - RC_W'(1);
            end
         end
         S_START: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // fin on the last allowed cycle still wins over the timeout
            if (core_fin_i) begin
               rsp_data_d   = core_dout_i;
               rsp_err_d    = 1'b0;
               key_loaded_d = 1'b1;
               last_key_d   = core_key_q;
               last_mode_d  = core_mode_q;
               state_d      = S_RESP;
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               rsp_data_d   = '0;
               rsp_err_d    = 1'b1;
               key_loaded_d = 1'b0;
               state_d      = S_RESP;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_RESP: begin
            if (job.rsp_ready[ch_q]) begin
               rr_ptr_d   = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
               rsp_data_d = '0;
               rsp_err_d  = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with state_q.
      rsp_valid_d  = (state_d == S_RESP) ? (N_CH'(1) << ch_d) : '0;
      core_rst_n_d = (state_d != S_KRST);
      core_bgn_d   = (state_d == S_START);
      busy_d       = (state_d != S_IDLE);
   end

   // State and output registers; reset aborts any job in flight and holds the core in reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         ch_q         <= '0;
         key_loaded_q <= 1'b0;
         last_key_q   <= '0;
         last_mode_q  <= '0;
         core_key_q   <= '0;
         core_mode_q  <= '0;
         core_data_q  <= '0;
         core_rst_n_q <= 1'b0;
         core_bgn_q   <= 1'b0;
         timer_q      <= '0;
         rcnt_q       <= '0;
         rsp_valid_q  <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         ch_q         <= ch_d;
         key_loaded_q <= key_loaded_d;
         last_key_q   <= last_key_d;
         last_mode_q  <= last_mode_d;
         core_key_q   <= core_key_d;
         core_mode_q  <= core_mode_d;
         core_data_q  <= core_data_d;
         core_rst_n_q <= core_rst_n_d;
         core_bgn_q   <= core_bgn_d;
         timer_q      <= timer_d;
         rcnt_q       <= rcnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         busy_q       <= busy_d;
      end
   end

   assign job.rsp_valid = rsp_valid_q;
   assign job.rsp_data  = rsp_data_q;
   assign job.rsp_err   = rsp_err_q;
   assign core_rst_n_o  = core_rst_n_q;
   assign core_key_o    = core_key_q;
   assign core_mode_o   = core_mode_q;
   assign core_data_o   = core_data_q;
   assign core_bgn_o    = core_bgn_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_crypto_job_sequencer.sv
// Bench for crypto_job_sequencer: directed scenarios plus a randomized job mix, checked
// against a job-level reference model (round-robin pick, key reuse, timeout outcome).
module tb_crypto_job_sequencer;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 16;
   localparam int unsigned KW = 16;
   localparam int unsigned RC = 2;
   localparam int unsigned TO = 16;
   localparam int          NEVER = 0;

   logic          clk = 1'b0;
   logic          rst;
   logic          core_rst_n, core_bgn, core_fin, busy;
   logic [KW-1:0] core_key;
   logic [1:0]    core_mode;
   logic [DW-1:0] core_data, core_dout;

   crypto_job_if #(.N_CH(N), .DATA_W(DW), .KEY_W(KW)) job ();

   crypto_job_sequencer #(
      .N_CH(N), .DATA_W(DW), .KEY_W(KW), .RST_CYC(RC), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .job(job),
      .core_rst_n_o(core_rst_n), .core_key_o(core_key), .core_mode_o(core_mode),
      .core_data_o(core_data), .core_bgn_o(core_bgn), .core_fin_i(core_fin),
      .core_dout_i(core_dout), .busy_o(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- crypto core model ----------------
   int            core_lat = 1;
   int            fin_cnt  = 0;
   logic [DW-1:0] pend_dout;

   function automatic logic [DW-1:0] core_fn(input logic [1:0] m, input logic [KW-1:0] k,
                                             input logic [DW-1:0] d);
      if (m == 2'b01) return {d[7:0], d[15:8]} ^ k;
      return d + k;
   endfunction

   initial begin
      core_fin  = 1'b0;
      core_dout = '0;
      pend_dout = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            fin_cnt   = 0;
            core_fin  = 1'b0;
            core_dout = '0;
         end else begin
            core_fin  = 1'b0;
            core_dout = DW'($urandom);
            if (fin_cnt > 0) begin
               fin_cnt--;
               if (fin_cnt == 0) begin
                  core_fin  = 1'b1;
                  core_dout = pend_dout;
               end
            end
            if (core_bgn) begin
               fin_cnt   = core_lat;
               pend_dout = core_fn(core_mode, core_key, core_data);
            end
         end
      end
   end

   // cumulative cycle counters of core reset-low and start pulses
   int rstlow_cnt = 0;
   int bgn_cnt    = 0;
   always @(posedge clk) begin
      if (!rst && !core_rst_n) rstlow_cnt++;
      if (!rst && core_bgn)    bgn_cnt++;
   end

   // ---------------- job-level reference model ----------------
   int            m_rr;
   bit            m_loaded;
   logic [KW-1:0] m_lk;
   logic [1:0]    m_lm;
   bit            pend   [N];
   logic [1:0]    p_mode [N];
   logic [KW-1:0] p_key  [N];
   logic [DW-1:0] p_data [N];
   int            p_lat  [N];

   function automatic int model_grant();
      for (int k = 0; k < int'(N); k++) begin
         if (pend[(m_rr + k) % int'(N)]) return (m_rr + k) % int'(N);
      end
      return -1;
   endfunction

   function automatic bit any_pend();
      for (int k = 0; k < int'(N); k++) if (pend[k]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic raise(input int c, input logic [1:0] m, input logic [KW-1:0] k,
                        input logic [DW-1:0] d, input int lat);
      pend[c]   = 1'b1;
      p_mode[c] = m;
      p_key[c]  = k;
      p_data[c] = d;
      p_lat[c]  = lat;
      job.req_mode[c*2 +: 2]   = m;
      job.req_key[c*KW +: KW]  = k;
      job.req_data[c*DW +: DW] = d;
      job.req_valid[c]         = 1'b1;
   endtask

   task automatic model_reset();
      m_rr     = 0;
      m_loaded = 1'b0;
      m_lk     = '0;
      m_lm     = '0;
      for (int k = 0; k < int'(N); k++) pend[k] = 1'b0;
   endtask

   // Serve the job the model expects to be granted next and check everything about it.
   task automatic serve_one(input int hold);
      int            c, cyc, lat, exp_lat, r0, b0, oth;
      bit            vmode, reload, ok;
      logic [DW-1:0] exp_d;
      logic          exp_e;
      c = model_grant();
      if (c < 0) return;
      lat      = p_lat[c];
      core_lat = lat;
      #1;
      check("grant", 32'(job.req_ready), 32'(1) << c);
      vmode  = (p_mode[c] == 2'b01) || (p_mode[c] == 2'b10);
      reload = vmode && !(m_loaded && (m_lk == p_key[c]) && (m_lm == p_mode[c]));
      ok     = vmode && (lat != NEVER) && (lat <= int'(TO));
      if (!vmode) begin
         exp_lat = 0;
         exp_d   = '0;
         exp_e   = 1'b1;
      end else begin
         exp_lat = (reload ? int'(RC) : 0) + (ok ? lat : int'(TO)) + 1;
         exp_d   = ok ? core_fn(p_mode[c], p_key[c], p_data[c]) : '0;
         exp_e   = !ok;
      end
      r0 = rstlow_cnt;
      b0 = bgn_cnt;
      tick();
      pend[c]          = 1'b0;
      job.req_valid[c] = 1'b0;
      check("bgn_after_accept", 32'(core_bgn), 32'(vmode && !reload));
      cyc = 0;
      while (job.rsp_valid == '0 && cyc < 200) begin
         tick();
         cyc++;
      end
      check("latency", 32'(cyc), 32'(exp_lat));
      check("rsp_valid", 32'(job.rsp_valid), 32'(1) << c);
      check("rsp_data", 32'(job.rsp_data), 32'(exp_d));
      check("rsp_err", 32'(job.rsp_err), 32'(exp_e));
      check("busy_resp", 32'(busy), 32'd1);
      check("rst_low_cycles", 32'(rstlow_cnt - r0), reload ? 32'(RC) : 32'd0);
      check("bgn_pulses", 32'(bgn_cnt - b0), vmode ? 32'd1 : 32'd0);
      if (vmode) begin
         check("core_key", 32'(core_key), 32'(p_key[c]));
         check("core_mode", 32'(core_mode), 32'(p_mode[c]));
      end
      oth = (c + 1) % int'(N);
      for (int h = 0; h < hold; h++) begin
         job.rsp_ready      = '0;
         job.rsp_ready[oth] = 1'b1;
         tick();
         check("hold_valid", 32'(job.rsp_valid), 32'(1) << c);
         check("hold_data", 32'(job.rsp_data), 32'(exp_d));
         check("hold_err", 32'(job.rsp_err), 32'(exp_e));
      end
      job.rsp_ready    = '0;
      job.rsp_ready[c] = 1'b1;
      tick();
      job.rsp_ready = '0;
      check("rsp_release", 32'(job.rsp_valid), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      if (vmode) begin
         if (ok) begin
            m_loaded = 1'b1;
            m_lk     = p_key[c];
            m_lm     = p_mode[c];
         end else begin
            m_loaded = 1'b0;
         end
      end
      m_rr = (c + 1) % int'(N);
   endtask

   function automatic logic [1:0] rnd_mode();
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4) return 2'b01;
      if (r < 8) return 2'b10;
      if (r == 8) return 2'b00;
      return 2'b11;
   endfunction

   function automatic int rnd_lat();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return NEVER;
      if (r == 1) return int'(TO) + 1;
      if (r == 2) return int'(TO);
      return int'($urandom_range(1, 6));
   endfunction

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [KW-1:0] keys [3];
      keys[0] = 16'h1325;
      keys[1] = 16'h5A5A;
      keys[2] = 16'hC0DE;

      rst           = 1'b1;
      job.req_valid = '0;
      job.req_mode  = '0;
      job.req_key   = '0;
      job.req_data  = '0;
      job.rsp_ready = '0;
      model_reset();
      repeat (3) tick();

      // reset values
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_valid", 32'(job.rsp_valid), 32'd0);
      check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
      check("rst_core_bgn", 32'(core_bgn), 32'd0);
      check("rst_core_key", 32'(core_key), 32'd0);
      check("rst_rsp_err", 32'(job.rsp_err), 32'd0);
      rst = 1'b0;
      tick();
      check("post_rst_core_rst_n", 32'(core_rst_n), 32'd1);

      // request withdrawn before the accept edge creates no job
      job.req_valid[2] = 1'b1;
      #1;
      check("withdraw_ready", 32'(job.req_ready), 32'h4);
      job.req_valid[2] = 1'b0;
      tick();
      check("withdraw_busy", 32'(busy), 32'd0);

      // first job loads the key; repeat reuses it without a reload
      raise(0, 2'b01, 16'h1325, 16'h00AB, 5);
      serve_one(2);
      raise(0, 2'b01, 16'h1325, 16'h0077, 3);
      serve_one(0);

      // invalid mode
      raise(2, 2'b11, 16'h1325, 16'hFFFF, 4);
      serve_one(1);

      // timeout on ch3, then fin exactly at the limit and one past it
      raise(3, 2'b01, 16'h5A5A, 16'h0101, NEVER);
      serve_one(0);
      raise(2, 2'b10, 16'hC0DE, 16'h2222, int'(TO));
      serve_one(0);
      raise(3, 2'b10, 16'hC0DE, 16'h3333, int'(TO) + 1);
      serve_one(0);

      // round robin from ch0 over 1,2,3; ch0 raised during ch1 job comes after ch3
      raise(1, 2'b10, 16'hC0DE, 16'h1111, 2);
      raise(2, 2'b10, 16'hC0DE, 16'h2222, 2);
      raise(3, 2'b01, 16'hC0DE, 16'h3333, 4);
      serve_one(0);
      raise(0, 2'b01, 16'hC0DE, 16'h4444, 1);
      serve_one(0);
      serve_one(1);
      serve_one(0);

      // reset during WAIT aborts the job; re-submitted job reloads the key
      raise(1, 2'b10, 16'hBEEF, 16'h1234, NEVER);
      core_lat = NEVER;
      #1;
      check("abort_grant", 32'(job.req_ready), 32'h2);
      tick();
      pend[1]          = 1'b0;
      job.req_valid[1] = 1'b0;
      repeat (RC + 4) tick();
      check("abort_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rsp_valid", 32'(job.rsp_valid), 32'd0);
      check("abort_core_rst_n", 32'(core_rst_n), 32'd0);
      tick();
      rst = 1'b0;
      model_reset();
      tick();
      raise(1, 2'b10, 16'hBEEF, 16'h1234, 3);
      serve_one(0);

      // randomized job mix
      for (int it = 0; it < 40; it++) begin
         for (int c = 0; c < int'(N); c++) begin
            if (!pend[c] && $urandom_range(0, 2) == 0)
               raise(c, rnd_mode(), keys[$urandom_range(0, 2)], DW'($urandom), rnd_lat());
         end
         if (!any_pend())
            raise(int'($urandom_range(0, N - 1)), rnd_mode(), keys[$urandom_range(0, 2)],
                  DW'($urandom), rnd_lat());
         serve_one(int'($urandom_range(0, 2)));
      end
      for (int k = 0; k < int'(N); k++) if (any_pend()) serve_one(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
